// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: two producers share one FIFO write port. A round-robin
// arbiter picks at most one push per cycle, and the block tracks FIFO
// occupancy so it never over-pushes or over-pops. A flush pulse drains the
// FIFO by issuing back-to-back pops. All strobes are registered.
module fifo_push_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  input  logic             rd_req,
  input  logic             flush,
  output logic             gnt0,
  output logic             gnt1,
  output logic             fifo_push,
  output logic [WIDTH-1:0] fifo_wdata,
  output logic             fifo_pop,
  output logic [OCC_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             busy
);

  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             last_q, last_d;   // 0: producer 0 won last, 1: producer 1
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             push_q, push_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             pop_q, pop_d;

  logic             push_ok;
  logic             pop_ok;
  logic             win0;
  logic             win1;

  // Saturating occupancy update: never above DEPTH, never below zero.
  function automatic logic [OCC_W-1:0] occ_next_f(
    input logic [OCC_W-1:0] occ,
    input logic             push,
    input logic             pop
  );
    logic [OCC_W-1:0] res;
    res = occ;
    if (push && !pop) begin
      res = (occ >= DEPTH_C) ? DEPTH_C : occ + OCC_W'(1);
    end else if (pop && !push) begin
      res = (occ == '0) ? '0 : occ - OCC_W'(1);
    end
    return res;
  endfunction

  // Next-state: arbitration, pop issue, occupancy and FSM transitions.
  always_comb begin
    push_ok = (occ_q < DEPTH_C);
    pop_ok  = (occ_q != '0);
    win0    = 1'b0;
    win1    = 1'b0;
    state_d = state_q;
    pop_d   = 1'b0;

    case (state_q)
      ST_RUN: begin
        // Pops are still honoured on the edge that accepts a flush.
        pop_d = rd_req & pop_ok;
        if (flush) begin
          state_d = ST_FLUSH;
        end else if (push_ok) begin
          if (req0 && req1) begin
            // Tie: the producer that did not win last time goes first.
            win0 = last_q;
            win1 = ~last_q;
          end else begin
            win0 = req0;
            win1 = req1;
          end
        end
      end
      ST_FLUSH: begin
        pop_d = pop_ok;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    gnt0_d = win0;
    gnt1_d = win1;
    push_d = win0 | win1;

    if (win0) begin
      wdata_d = data0;
      last_d  = 1'b0;
    end else if (win1) begin
      wdata_d = data1;
      last_d  = 1'b1;
    end else begin
      wdata_d = wdata_q;
      last_d  = last_q;
    end

    occ_d = occ_next_f(occ_q, push_d, pop_d);

    // Leave FLUSH on the edge that empties the FIFO (or at once if empty).
    if ((state_q == ST_FLUSH) && (occ_d == '0)) begin
      state_d = ST_RUN;
    end
  end

  // State and registered outputs; reset overrides everything, even mid-flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      occ_q   <= '0;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      push_q  <= 1'b0;
      wdata_q <= '0;
      pop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      last_q  <= last_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      push_q  <= push_d;
      wdata_q <= wdata_d;
      pop_q   <= pop_d;
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign fifo_push  = push_q;
  assign fifo_wdata = wdata_q;
  assign fifo_pop   = pop_q;
  assign occupancy  = occ_q;
  assign full       = (occ_q == DEPTH_C);
  assign empty      = (occ_q == '0);
  assign busy       = (state_q == ST_FLUSH);

endmodule

// File: doc/fifo_push_arbiter.md
FIFO_PUSH_ARBITER -- requirements
Module: fifo_push_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data width of each producer and of the FIFO write port.
REQ-002 Parameter DEPTH, default 4, capacity of the downstream FIFO in entries.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req0  input  1  producer 0 requests a push this cycle.
REQ-006 data0  input  WIDTH  producer 0 write data, sampled with req0.
REQ-007 req1  input  1  producer 1 requests a push this cycle.
REQ-008 data1  input  WIDTH  producer 1 write data, sampled with req1.
REQ-009 rd_req  input  1  consumer requests a pop this cycle.
REQ-010 flush  input  1  single-cycle pulse; drains the FIFO by repeated pops.
REQ-011 gnt0  output  1  registered; producer 0's request sampled on the previous edge was accepted.
REQ-012 gnt1  output  1  registered; producer 1's request sampled on the previous edge was accepted.
REQ-013 fifo_push  output  1  registered push strobe to the FIFO.
REQ-014 fifo_wdata  output  WIDTH  registered write data; valid when fifo_push=1.
REQ-015 fifo_pop  output  1  registered pop strobe to the FIFO.
REQ-016 occupancy  output  $clog2(DEPTH+1)  registered count of entries issued and not yet popped; range 0..DEPTH.
REQ-017 full  output  1  occupancy==DEPTH, combinational from the register.
REQ-018 empty  output  1  occupancy==0, combinational from the register.
REQ-019 busy  output  1  1 while the FSM is in FLUSH.

Function
REQ-020 The FSM SHALL have two states: RUN and FLUSH.
REQ-021 In RUN, each edge: push_ok = (occupancy<DEPTH); pop_ok = (occupancy>0).
REQ-022 Single requester with push_ok: that requester wins.
REQ-023 Both requesting with push_ok: the winner SHALL be the requester other than last_winner (round-robin).
REQ-024 On a win, the edge SHALL set gnt<n>=1, fifo_push=1, fifo_wdata=data<n>, and last_winner=n; all three outputs are high for exactly one cycle per win.
REQ-025 No win (no request, or !push_ok): gnt0=gnt1=fifo_push=0 next cycle; fifo_wdata holds its previous value; last_winner unchanged.
REQ-026 The losing or blocked requester SHALL receive no grant and must hold req; there is no queuing inside the block.
REQ-027 rd_req with pop_ok SHALL set fifo_pop=1 for one cycle; rd_req when empty SHALL be ignored.
REQ-028 occupancy_next = occupancy + push_issued - pop_issued, evaluated on the same edge as the decisions; push and pop in the same cycle leave occupancy unchanged.
REQ-029 No bypass: at full, a simultaneous rd_req and req pops only; at empty, a simultaneous req and rd_req pushes only.
REQ-030 Latency: request sampled at edge N -> gnt/fifo_push/fifo_pop high during cycle N+1; occupancy updates at edge N.
REQ-031 flush in RUN SHALL move to FLUSH on the next edge; that edge still evaluates pops, but no grants are issued.
REQ-032 In FLUSH: no grants are issued; fifo_pop SHALL be issued every cycle while occupancy>0, regardless of rd_req; the FSM SHALL return to RUN on the edge where occupancy becomes 0, or immediately if occupancy is already 0.
REQ-033 flush while in FLUSH SHALL be ignored.
REQ-034 occupancy SHALL never exceed DEPTH or wrap below 0.

Reset
REQ-035 On reset: state=RUN, occupancy=0, last_winner=1 (so producer 0 wins the first tie).
REQ-036 On reset: gnt0=gnt1=fifo_push=fifo_pop=busy=0 and fifo_wdata=0.
REQ-037 Reset SHALL take priority over all inputs, including mid-FLUSH; any pending request is dropped.

Verification
REQ-038 Reset, then req0=req1=1 held, data0=0xA, data1=0xB, no rd_req -> pushes alternate 0xA,0xB,0xA,0xB; full=1 after the 4th; no further gnt.
REQ-039 At full, rd_req=1 and req0=1 for one cycle -> fifo_pop=1, fifo_push=0, occupancy 4->3.
REQ-040 occupancy=2, req1=1 and rd_req=1 together -> fifo_push and fifo_pop both 1 next cycle; occupancy stays 2.
REQ-041 occupancy=3, flush pulse, req0 held -> busy=1; three consecutive fifo_pop cycles; no gnt0; busy=0 once occupancy=0; gnt0 resumes next cycle.
REQ-042 Empty, rd_req=1 -> fifo_pop stays 0 and occupancy stays 0.
REQ-043 Reset asserted during FLUSH with occupancy=2 -> next cycle busy=0, occupancy=0, all strobes 0.
